if_fetch_ctrl: RTL
==================

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000: PC value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, range 2..255: cycles in REQ without ack before fault.
REQ-003 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 i_reset_n  input  1  synchronous, active-low reset, sampled on the i_clk rising edge.
REQ-005 i_stall  input  1  hazard hold: the presented instruction is not consumed this cycle.
REQ-006 i_redirect  input  1  branch/jump taken; fetch restarts at i_redirectAddr.
REQ-007 i_redirectAddr  input  32  redirect target.
REQ-008 o_memReq  output  1  instruction-memory request.
REQ-009 o_memAddr  output  32  request address; always equal to the current PC.
REQ-010 i_memAck  input  1  memory returns i_memData this cycle; ignored unless o_memReq=1.
REQ-011 i_memData  input  32  fetched instruction word.
REQ-012 o_valid  output  1  o_instruction/o_pc hold a deliverable instruction.
REQ-013 o_instruction  output  32  registered instruction to ID.
REQ-014 o_pc  output  32  address of o_instruction.
REQ-015 o_fault  output  1  sticky fetch-timeout flag.

Function
REQ-016 FSM states SHALL be IDLE, REQ, HOLD and FAULT, with all outputs registered.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-018 In REQ, o_memReq SHALL be 1 and o_valid 0; REQ holds until i_memAck=1, and i_stall has no effect in REQ.
REQ-019 On REQ with i_memAck=1 and i_redirect=0, the edge SHALL load o_instruction<=i_memData, o_pc<=PC, o_valid<=1, state<=HOLD.
REQ-020 In HOLD, o_memReq SHALL be 0; with i_stall=1 all outputs SHALL hold.
REQ-021 On HOLD with i_stall=0 the instruction is consumed: the edge SHALL set PC<=PC+4, o_valid<=0, state<=REQ.
REQ-022 Minimum throughput SHALL be one instruction per 2 cycles with zero-wait memory.
REQ-023 Ack-to-o_valid latency SHALL be 1 cycle.
REQ-024 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 i_redirect=1 in IDLE, REQ or HOLD SHALL set PC<=i_redirectAddr with bits [1:0] forced to 0, o_valid<=0, state<=REQ, and clear the timeout counter.
REQ-026 i_redirect SHALL take priority over a simultaneous i_memAck (data discarded) and over i_stall.
REQ-027 In FAULT, o_memReq=0, o_valid=0 and o_fault=1; i_redirect SHALL be ignored and only reset exits FAULT.

Reset
REQ-028 When i_reset_n=0 at an edge, the state SHALL become IDLE; PC=o_pc=RESET_ADDR, o_instruction=32'h0000_0013 (NOP), o_valid=0, o_memReq=0, o_fault=0, timeout counter=0.
REQ-029 Reset SHALL override every other input, including mid-request and in FAULT; an outstanding request is abandoned and a late i_memAck is ignored.

Configuration
REQ-030 Macro IF_FETCH_TIMEOUT_EN SHALL compile the timeout feature in or out.
REQ-031 With IF_FETCH_TIMEOUT_EN defined, an 8-bit counter SHALL increment each REQ cycle without ack and clear on ack, redirect or leaving REQ.
REQ-032 With IF_FETCH_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL enter FAULT on that edge.
REQ-033 Without IF_FETCH_TIMEOUT_EN, no counter or FAULT logic SHALL exist, o_fault SHALL be tied 0, REQ SHALL wait indefinitely, and the port list is unchanged.

Verification
REQ-034 Zero-wait stream: reset release, ack every REQ cycle -> o_pc sequence 0,4,8,12 with o_valid high every other cycle.
REQ-035 Stall: i_stall=1 for 3 cycles in HOLD at pc=8 -> o_valid/o_pc/o_instruction stable 3 cycles, then next o_pc=12.
REQ-036 Redirect with ack: i_redirect=1, i_redirectAddr=32'h0000_0103 coincident with i_memAck -> data dropped, next o_memAddr=32'h0000_0100.
REQ-037 Wrap: RESET_ADDR=32'hFFFF_FFFC, one consumed fetch -> next o_memAddr=32'h0000_0000.
REQ-038 Timeout (macro on, TIMEOUT_CYCLES=4): no ack -> o_fault=1 after 4 REQ cycles, redirect ignored, reset clears fault; macro off -> o_fault stays 0 and o_memReq stays high.
REQ-039 Mid-request reset: i_reset_n=0 while in REQ with a pending ack -> all outputs at reset values next cycle, and an ack during IDLE is ignored.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch controller.
// Walks the PC through IDLE -> REQ -> HOLD, presenting one registered
// instruction at a time to decode. Redirects restart fetch at a new target.
// Optional feature macro: IF_FETCH_TIMEOUT_EN
//   When defined, a request left unacknowledged for TIMEOUT_CYCLES cycles
//   parks the block in a sticky FAULT state that only reset can clear.
//   When undefined, REQ waits indefinitely and o_fault is tied low.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR     = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirectAddr,
    output logic        o_memReq,
    output logic [31:0] o_memAddr,
    input  logic        i_memAck,
    input  logic [31:0] i_memData,
    output logic        o_valid,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic        o_fault
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    // Low address bits are always cleared so the PC stays word aligned.
    localparam logic [31:0] RESET_PC  = {RESET_ADDR[31:2], 2'b00};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] out_pc_reg;
    logic        valid_reg;
    logic        mem_req_reg;

`ifdef IF_FETCH_TIMEOUT_EN
    // Counter value seen on the last unacknowledged REQ cycle before faulting.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] timeout_cnt_reg;
    logic       fault_reg;
`else
    // Parameter kept for a stable interface; it has no effect in this build.
    logic [7:0] timeout_param_unused;
    assign timeout_param_unused = 8'(TIMEOUT_CYCLES);
`endif

    // Fetch FSM: state, PC and every output register updated together.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            out_pc_reg      <= RESET_PC;
            instr_reg       <= NOP_INSTR;
            valid_reg       <= 1'b0;
            mem_req_reg     <= 1'b0;
`ifdef IF_FETCH_TIMEOUT_EN
            timeout_cnt_reg <= 8'd0;
            fault_reg       <= 1'b0;
`endif
        end else
`ifdef IF_FETCH_TIMEOUT_EN
        if (state_reg == FAULT) begin
            // Sticky: redirects and acks are ignored until reset.
            mem_req_reg <= 1'b0;
            valid_reg   <= 1'b0;
            fault_reg   <= 1'b1;
        end else
`endif
        if (i_redirect) begin
            // Redirect wins over ack (data dropped) and over stall.
            state_reg   <= REQ;
            pc_reg      <= {i_redirectAddr[31:2], 2'b00};
            valid_reg   <= 1'b0;
            mem_req_reg <= 1'b1;
`ifdef IF_FETCH_TIMEOUT_EN
            timeout_cnt_reg <= 8'd0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg   <= REQ;
                    mem_req_reg <= 1'b1;
                end
                REQ: begin
                    if (i_memAck) begin
                        state_reg   <= HOLD;
                        instr_reg   <= i_memData;
                        out_pc_reg  <= pc_reg;
                        valid_reg   <= 1'b1;
                        mem_req_reg <= 1'b0;
`ifdef IF_FETCH_TIMEOUT_EN
                        timeout_cnt_reg <= 8'd0;
                    end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                        state_reg       <= FAULT;
                        mem_req_reg     <= 1'b0;
                        valid_reg       <= 1'b0;
                        fault_reg       <= 1'b1;
                        timeout_cnt_reg <= 8'd0;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
`endif
                    end
                end
                HOLD: begin
                    // Stall holds everything; otherwise decode consumed it.
                    if (!i_stall) begin
                        state_reg   <= REQ;
                        pc_reg      <= pc_reg + 32'd4;
                        valid_reg   <= 1'b0;
                        mem_req_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_memReq      = mem_req_reg;
    assign o_memAddr     = pc_reg;
    assign o_valid       = valid_reg;
    assign o_instruction = instr_reg;
    assign o_pc          = out_pc_reg;
`ifdef IF_FETCH_TIMEOUT_EN
    assign o_fault       = fault_reg;
`else
    assign o_fault       = 1'b0;
`endif

endmodule
